// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter.
//   state_e    : arbiter sequencing state (IDLE / CORE_RD)
//   rd_owner_e : which requester receives mem_rdata in the current cycle
package data_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    CORE_RD = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between core load/store port, debug/DMA port and the data RAM.
//   slave  : arbiter view (consumes requests, drives grants/data/memory controls)
//   master : environment view (core, debug block and RAM)
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              core_en_load;
  logic              core_en_store;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_en_load, core_en_store, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output core_rdata, core_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_en_load, core_en_store, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  core_rdata, core_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the debug port waited without a grant.
//   clk, rst : clock, async active-low reset
//   inc_i    : debug waiting this cycle
//   clr_i    : debug granted or not requesting
//   cnt_o    : current wait count, saturates at LIMIT
module data_mem_arbiter_starve_counter #(
  parameter int LIMIT = 4,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != CW'(LIMIT))) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one synchronous data RAM between the core load/store port (fixed
// priority) and a debug/DMA port, with a starvation escape for debug.
//   clk, rst : clock, async active-low reset
//   bus      : core, debug and memory signals (slave modport)
// Core loads take two cycles (issue + stall, then data); the data-return
// cycle's memory slot is only ever given to debug.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  rd_owner_e         owner_q, owner_d;
  logic [CW-1:0]     wait_cnt;
  logic              core_req, forced, core_issue, dbg_issue;
  logic              mem_en, mem_we, core_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d    = IDLE;
    owner_d    = NONE;
    core_issue = 1'b0;
    dbg_issue  = 1'b0;
    core_stall = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_req   = bus.core_en_load || bus.core_en_store;
    forced     = (state_q == IDLE) && bus.dbg_req && (wait_cnt == CW'(STARVE_LIMIT));

    // Outputs are gated by rst so enables drop the instant reset asserts,
    // not only after the registers clear.
    if (rst) begin
      if (forced) begin
        dbg_issue  = 1'b1;
        core_stall = core_req;
      end else if ((state_q == IDLE) && core_req) begin
        core_issue = 1'b1;
      end else begin
        // In CORE_RD the core's held request is the completing load, never a new one.
        dbg_issue = bus.dbg_req;
      end
    end

    if (core_issue) begin
      mem_en = 1'b1;
      mem_addr = bus.core_addr;
      if (bus.core_en_load) begin
        core_stall = 1'b1;
        state_d    = CORE_RD;
        owner_d    = CORE;
      end else begin
        mem_we    = 1'b1;
        mem_wdata = bus.core_wdata;
      end
    end

    if (dbg_issue) begin
      mem_en   = 1'b1;
      mem_we   = bus.dbg_we;
      mem_addr = bus.dbg_addr;
      if (bus.dbg_we) begin
        mem_wdata = bus.dbg_wdata;
      end else begin
        owner_d = DBG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  data_mem_arbiter_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bus.dbg_req && !dbg_issue),
    .clr_i (!bus.dbg_req || dbg_issue),
    .cnt_o (wait_cnt)
  );

  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.core_stall = core_stall;
  assign bus.dbg_gnt    = dbg_issue;
  assign bus.dbg_rvalid = (owner_q == DBG);
  assign bus.dbg_rdata  = (owner_q == DBG)  ? bus.mem_rdata : '0;
  assign bus.core_rdata = (owner_q == CORE) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Reference model state: memory contents, pending core load, debug wait.
  logic [DW-1:0] ref_mem [1024];
  bit            rd_pending;
  int            waited;
  bit            last_stall, last_gnt;
  logic [DW-1:0] core_q[$];
  logic [DW-1:0] dbg_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arbitration rules applied to the inputs currently driven.
  task automatic step();
    bit ld, st, dr, dw, creq, ci, di, e_stall, e_en, e_we;
    int e_addr, e_wd;
    ld = bus.core_en_load; st = bus.core_en_store;
    dr = bus.dbg_req;      dw = bus.dbg_we;
    creq = ld || st;
    ci = 0; di = 0; e_stall = 0;
    if (rd_pending)                    di = dr;
    else if (dr && waited >= STARVE) begin di = 1; e_stall = creq; end
    else if (creq)                begin ci = 1; e_stall = ld; end
    else                               di = dr;
    e_en = ci || di; e_we = 0; e_addr = 0; e_wd = 0;
    if (ci) begin
      e_addr = int'(bus.core_addr);
      e_we = !ld;
      if (!ld) e_wd = int'(bus.core_wdata);
    end
    if (di) begin
      e_addr = int'(bus.dbg_addr);
      e_we = dw;
      if (dw) e_wd = int'(bus.dbg_wdata);
    end
    chk("core_stall", int'(bus.core_stall), int'(e_stall));
    chk("dbg_gnt",    int'(bus.dbg_gnt),    int'(di));
    chk("mem_en",     int'(bus.mem_en),     int'(e_en));
    chk("mem_we",     int'(bus.mem_we),     int'(e_we));
    chk("mem_addr",   int'(bus.mem_addr),   e_addr);
    chk("mem_wdata",  int'(bus.mem_wdata),  e_wd);
    if (ci && ld)  core_q.push_back(ref_mem[bus.core_addr]);
    if (di && !dw) dbg_q.push_back(ref_mem[bus.dbg_addr]);
    if (e_en && e_we) ref_mem[e_addr] = DW'(e_wd);
    rd_pending = ci && ld;
    waited = (dr && !di) ? ((waited < STARVE) ? waited + 1 : STARVE) : 0;
    last_stall = e_stall;
    last_gnt = di;
  endtask

  task automatic drive(input bit ld, input bit st, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cw, input bit dr, input bit dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    @(negedge clk);
    bus.core_en_load = ld; bus.core_en_store = st;
    bus.core_addr = ca;    bus.core_wdata = cw;
    bus.dbg_req = dr;      bus.dbg_we = dw;
    bus.dbg_addr = da;     bus.dbg_wdata = dwd;
    #1 step();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_en"},     int'(bus.mem_en),     0);
    chk({tag, "_mem_we"},     int'(bus.mem_we),     0);
    chk({tag, "_core_stall"}, int'(bus.core_stall), 0);
    chk({tag, "_dbg_gnt"},    int'(bus.dbg_gnt),    0);
    chk({tag, "_dbg_rvalid"}, int'(bus.dbg_rvalid), 0);
    chk({tag, "_core_rdata"}, int'(bus.core_rdata), 0);
    chk({tag, "_dbg_rdata"},  int'(bus.dbg_rdata),  0);
  endtask

  // Monitor: pops expected read data whenever the DUT presents a response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (bus.dbg_rvalid) begin
          if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 1, 0);
          else chk("dbg_rdata", int'(bus.dbg_rdata), int'(dbg_q.pop_front()));
        end
        if (bus.core_en_load && !bus.core_stall) begin
          if (core_q.size() == 0) chk("core_done_unexpected", 1, 0);
          else chk("core_rdata", int'(bus.core_rdata), int'(core_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bit ld, st, dr, dw, hold_core;
    logic [AW-1:0] ca, da;
    logic [DW-1:0] cw, dwd;
    int r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rd_pending = 0; waited = 0;
    bus.core_en_load = 0; bus.core_en_store = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    #2 chk_quiet("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Core store, then core load of the same word.
    drive(0, 1, 10'h005, 8'hA5, 0, 0, 0, 0);
    drive(1, 0, 10'h005, 0, 0, 0, 0, 0);
    drive(1, 0, 10'h005, 0, 0, 0, 0, 0);
    // Debug write 0x3C to 0x010 while core idle, then core load + debug read.
    drive(0, 0, 0, 0, 1, 1, 10'h010, 8'h3C);
    drive(1, 0, 10'h005, 0, 1, 0, 10'h010, 0);
    drive(1, 0, 10'h005, 0, 1, 0, 10'h010, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Starvation: continuous core stores with debug held.
    for (int i = 0; i < 5; i++) drive(0, 1, 10'h020, 8'h11, 1, 0, 10'h005, 0);
    drive(0, 1, 10'h020, 8'h11, 0, 0, 0, 0);
    // Idle-core debug write to the top address.
    drive(0, 0, 0, 0, 1, 1, 10'h3FF, 8'hFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset while a debug read granted in the CORE_RD slot is in flight.
    drive(1, 0, 10'h3FF, 0, 0, 0, 0, 0);
    drive(1, 0, 10'h3FF, 0, 1, 0, 10'h005, 0);
    #3 rst = 1'b0;
    #1 chk_quiet("rst_mid");
    @(negedge clk);
    bus.core_en_load = 0; bus.dbg_req = 0;
    rst = 1'b1;
    rd_pending = 0; waited = 0;
    core_q.delete(); dbg_q.delete();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0);
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0);

    // Seed the random working set so every read targets a written word.
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, 1, AW'(i), DW'($urandom));

    hold_core = 0; dr = 0; ld = 0; st = 0; ca = '0; cw = '0; dw = 0; da = '0; dwd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold_core) begin
        r = $urandom_range(0, 3);
        ld = (r == 1); st = (r >= 2);
        ca = AW'($urandom_range(0, 15)); cw = DW'($urandom);
      end
      if (dr && $urandom_range(0, 7) == 0) dr = 0;
      else if (!dr && $urandom_range(0, 2) == 0) begin
        dr = 1; dw = ($urandom_range(0, 1) == 1);
        da = AW'($urandom_range(0, 15)); dwd = DW'($urandom);
      end
      drive(ld, st, ca, cw, dr, dw, da, dwd);
      hold_core = last_stall;
      if (last_gnt) dr = 0;
    end
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("core_q_left", core_q.size(), 0);
    chk("dbg_q_left", dbg_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
